dm_spi_dac_responder: RTL and testbench

- Synthesizable SPI responder: the far end of the DM driver's per-port SPI master (Mosi/Sck/nCs[3:0], Miso).
- Emulates one port's four daisy-less DAC devices. Oversamples the SPI lines in the fabric clock domain and captures MSB-first words per chip select.
- Echoes each channel's previous word back on Miso, so a sandbox build can loop-test the DM SPI engines without hardware.

---
 rtl/dm_spi_dac_responder_if.sv | 25 ++
 rtl/dm_spi_dac_responder.sv | 200 ++++++++++++++++++++
 tb/tb_dm_spi_dac_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dm_spi_dac_responder_if.sv
// Link between the DM per-port SPI master and the DAC responder: SPI lines plus
// the responder's receive report.
interface dm_spi_dac_responder_if #(
    parameter int WORD_BITS = 24
);
    logic                 Sck;
    logic                 Mosi;
    logic [3:0]           nCs;
    logic                 Miso;
    logic [WORD_BITS-1:0] RxData;
    logic [1:0]           RxChannel;
    logic                 RxValid;
    logic                 FrameErr;
    logic [15:0]          FrameCount;

    modport master (
        output Sck, Mosi, nCs,
        input  Miso, RxData, RxChannel, RxValid, FrameErr, FrameCount
    );

    modport slave (
        input  Sck, Mosi, nCs,
        output Miso, RxData, RxChannel, RxValid, FrameErr, FrameCount
    );
endinterface

// File: rtl/dm_spi_dac_responder.sv
// Oversampled mode-0 SPI responder emulating four DAC chip selects; each channel
// echoes its previously accepted word on Miso so DM SPI engines can be loop-tested.
module dm_spi_dac_responder #(
    parameter int WORD_BITS = 24,
    parameter int NUM_CS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dm_spi_dac_responder_if.slave spi
);
    localparam int               CNT_W    = $clog2(WORD_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FINISH = 2'd2
    } stateE;

    stateE stateR, stateNextS;

    logic                 sckMetaR, sckSyncR, sckPrevR;
    logic                 mosiMetaR, mosiSyncR;
    logic [3:0]           nCsMetaR, nCsSyncR;
    logic                 armedR;
    logic [1:0]           chR;
    logic                 errR;
    logic [CNT_W-1:0]     cntR;
    logic [WORD_BITS-1:0] rxShiftR;
    logic [WORD_BITS-1:0] txShiftR;
    logic [WORD_BITS-1:0] readbackR [NUM_CS];
    logic                 misoR;
    logic [WORD_BITS-1:0] rxDataR;
    logic [1:0]           rxChannelR;
    logic                 rxValidR;
    logic                 frameErrR;
    logic [15:0]          frameCountR;

    logic       sckRiseS, sckFallS, nCsAllHighS;
    logic [1:0] lowIdxS;
    logic       oneLowS;
    logic [3:0] selPatS;
    logic       startS, startErrS, shiftInS, shiftOutS, csBadS, acceptS, rejectS;

    // Two-stage synchronizers; sync regs reset non-idle so a held-low nCs is not mistaken for a fresh frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sckMetaR  <= 1'b0;
            sckSyncR  <= 1'b0;
            sckPrevR  <= 1'b0;
            mosiMetaR <= 1'b0;
            mosiSyncR <= 1'b0;
            nCsMetaR  <= 4'h0;
            nCsSyncR  <= 4'h0;
        end else begin
            sckMetaR  <= spi.Sck;
            sckSyncR  <= sckMetaR;
            sckPrevR  <= sckSyncR;
            mosiMetaR <= spi.Mosi;
            mosiSyncR <= mosiMetaR;
            nCsMetaR  <= spi.nCs;
            nCsSyncR  <= nCsMetaR;
        end
    end

    assign sckRiseS    = sckSyncR & ~sckPrevR;
    assign sckFallS    = ~sckSyncR & sckPrevR;
    assign nCsAllHighS = (nCsSyncR == 4'hF);
    assign selPatS     = ~(4'b0001 << chR);

    // Decode which single chip select is low
    always_comb begin
        lowIdxS = 2'd0;
        oneLowS = 1'b0;
        case (nCsSyncR)
            4'b1110: begin lowIdxS = 2'd0; oneLowS = 1'b1; end
            4'b1101: begin lowIdxS = 2'd1; oneLowS = 1'b1; end
            4'b1011: begin lowIdxS = 2'd2; oneLowS = 1'b1; end
            4'b0111: begin lowIdxS = 2'd3; oneLowS = 1'b1; end
            default: begin lowIdxS = 2'd0; oneLowS = 1'b0; end
        endcase
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Next state and per-cycle datapath strobes; leaving ACTIVE takes priority over a coincident Sck edge
    always_comb begin
        stateNextS = stateR;
        startS     = 1'b0;
        startErrS  = 1'b0;
        shiftInS   = 1'b0;
        shiftOutS  = 1'b0;
        csBadS     = 1'b0;
        acceptS    = 1'b0;
        rejectS    = 1'b0;
        case (stateR)
            IDLE: begin
                if (armedR && !nCsAllHighS) begin
                    stateNextS = ACTIVE;
                    startS     = oneLowS;
                    startErrS  = ~oneLowS;
                end else begin
                    stateNextS = IDLE;
                end
            end
            ACTIVE: begin
                if (nCsAllHighS) begin
                    stateNextS = FINISH;
                end else begin
                    stateNextS = ACTIVE;
                    shiftInS   = sckRiseS;
                    shiftOutS  = sckFallS;
                    csBadS     = (nCsSyncR != selPatS);
                end
            end
            FINISH: begin
                stateNextS = IDLE;
                acceptS    = ~errR && (cntR == CNT_FULL);
                rejectS    = ~acceptS;
            end
            default: begin
                stateNextS = IDLE;
            end
        endcase
    end

    // Capture/echo shifters, per-channel readback and the registered receive report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armedR      <= 1'b0;
            chR         <= 2'd0;
            errR        <= 1'b0;
            cntR        <= '0;
            rxShiftR    <= '0;
            txShiftR    <= '0;
            misoR       <= 1'b0;
            rxDataR     <= '0;
            rxChannelR  <= 2'd0;
            rxValidR    <= 1'b0;
            frameErrR   <= 1'b0;
            frameCountR <= 16'd0;
            for (int i = 0; i < NUM_CS; i++) begin
                readbackR[i] <= '0;
            end
        end else begin
            rxValidR  <= acceptS;
            frameErrR <= rejectS;
            misoR     <= (stateR == ACTIVE) ? txShiftR[WORD_BITS-1] : 1'b0;
            if (stateR == IDLE && nCsAllHighS) begin
                armedR <= 1'b1;
            end
            if (startS) begin
                chR      <= lowIdxS;
                cntR     <= '0;
                errR     <= 1'b0;
                rxShiftR <= '0;
                txShiftR <= readbackR[lowIdxS];
            end
            if (startErrS) begin
                cntR     <= '0;
                errR     <= 1'b1;
                rxShiftR <= '0;
                txShiftR <= '0;
            end
            if (shiftInS) begin
                rxShiftR <= {rxShiftR[WORD_BITS-2:0], mosiSyncR};
                if (cntR != CNT_MAX) begin
                    cntR <= cntR + CNT_W'(1);
                end
            end
            if (shiftOutS) begin
                txShiftR <= {txShiftR[WORD_BITS-2:0], 1'b0};
            end
            if (csBadS) begin
                errR <= 1'b1;
            end
            if (acceptS) begin
                rxDataR        <= rxShiftR;
                rxChannelR     <= chR;
                readbackR[chR] <= rxShiftR;
                frameCountR    <= frameCountR + 16'd1;
            end
        end
    end

    assign spi.Miso       = misoR;
    assign spi.RxData     = rxDataR;
    assign spi.RxChannel  = rxChannelR;
    assign spi.RxValid    = rxValidR;
    assign spi.FrameErr   = frameErrR;
    assign spi.FrameCount = frameCountR;
endmodule

// File: tb/tb_dm_spi_dac_responder.sv
// Scoreboard bench: a frame-level reference model predicts each report pulse and
// each echoed Miso word; a monitor pops predictions when a pulse appears.
module tb_dm_spi_dac_responder;
    localparam int HALF = 6;

    typedef struct {
        bit          isAcc;
        logic [23:0] data;
        logic [1:0]  ch;
        logic [15:0] cnt;
        int          cyc;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;

    expT         sbQ [$];
    logic [23:0] mdlReadback [4];
    logic [23:0] mdlData;
    logic [1:0]  mdlCh;
    logic [15:0] mdlCount;

    dm_spi_dac_responder_if #(.WORD_BITS(24)) bus ();

    dm_spi_dac_responder #(.WORD_BITS(24), .NUM_CS(4)) dut (
        .clk (clk),
        .rst (rst),
        .spi (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 4; i++) mdlReadback[i] = 24'h0;
        mdlData  = 24'h0;
        mdlCh    = 2'd0;
        mdlCount = 16'd0;
        sbQ.delete();
    endtask

    // Monitor: every report pulse must match the oldest outstanding prediction
    always @(negedge clk) begin
        expT e;
        if (!rst && (bus.RxValid || bus.FrameErr)) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got RxValid=%0b FrameErr=%0b expected none",
                         bus.RxValid, bus.FrameErr);
            end else begin
                e = sbQ.pop_front();
                chk("rxvalid", 32'(bus.RxValid), 32'(e.isAcc));
                chk("frameerr", 32'(bus.FrameErr), 32'(!e.isAcc));
                chk("rxdata", 32'(bus.RxData), 32'(e.data));
                chk("rxchannel", 32'(bus.RxChannel), 32'(e.ch));
                chk("framecount", 32'(bus.FrameCount), 32'(e.cnt));
                chk("latency", 32'(cycleCnt), 32'(e.cyc));
            end
        end
    end

    task automatic sendFrame(input logic [3:0] cs, input logic [23:0] word, input int nBits,
                             input int midAt, input logic [3:0] midCs, input int rstAt);
        int          lows;
        int          idx;
        bit          acc;
        bit          doEcho;
        logic [23:0] echo;
        logic [23:0] capt;
        expT         e;
        lows = 0;
        idx  = 0;
        for (int i = 0; i < 4; i++) begin
            if (!cs[i]) begin
                lows++;
                idx = i;
            end
        end
        acc    = (lows == 1) && (midAt < 0) && (nBits == 24) && (rstAt < 0);
        doEcho = (lows == 1) && (midAt < 0) && (rstAt < 0) && (nBits > 0) && (nBits <= 24);
        echo   = mdlReadback[idx];
        capt   = 24'h0;
        @(negedge clk);
        bus.nCs = cs;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nBits; i++) begin
            if (i == rstAt) begin
                rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("rst_framecount", 32'(bus.FrameCount), 32'h0);
                chk("rst_rxdata", 32'(bus.RxData), 32'h0);
                chk("rst_miso", 32'(bus.Miso), 32'h0);
                rst = 1'b0;
                resetModel();
            end
            if (i == midAt) bus.nCs = midCs;
            bus.Mosi = (i < 24) ? word[23-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            capt = {capt[22:0], bus.Miso};
            bus.Sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.Sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        bus.nCs = 4'hF;
        if (rstAt < 0) begin
            if (acc) begin
                mdlReadback[idx] = word;
                mdlData          = word;
                mdlCh            = 2'(idx);
                mdlCount         = mdlCount + 16'd1;
            end
            e.isAcc = acc;
            e.data  = mdlData;
            e.ch    = mdlCh;
            e.cnt   = mdlCount;
            e.cyc   = cycleCnt + 4;
            sbQ.push_back(e);
        end
        if (doEcho) chk("miso_echo", 32'(capt), 32'(echo >> (24 - nBits)));
        repeat (12) @(negedge clk);
        chk("sb_drained", 32'(sbQ.size()), 32'h0);
        chk("miso_idle", 32'(bus.Miso), 32'h0);
    endtask

    initial begin
        int          ch;
        int          r;
        int          nb;
        logic [3:0]  cs;
        resetModel();
        bus.Sck  = 1'b0;
        bus.Mosi = 1'b0;
        bus.nCs  = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset_rxdata", 32'(bus.RxData), 32'h0);
        chk("reset_rxchannel", 32'(bus.RxChannel), 32'h0);
        chk("reset_framecount", 32'(bus.FrameCount), 32'h0);
        chk("reset_miso", 32'(bus.Miso), 32'h0);
        chk("reset_pulses", 32'({bus.RxValid, bus.FrameErr}), 32'h0);
        rst = 1'b0;

        // Idle with Sck toggling and no chip select
        for (int i = 0; i < 8; i++) begin
            repeat (HALF) @(negedge clk);
            bus.Sck = ~bus.Sck;
        end
        repeat (HALF) @(negedge clk);
        chk("idle_framecount", 32'(bus.FrameCount), 32'h0);
        chk("idle_miso", 32'(bus.Miso), 32'h0);

        sendFrame(4'b1101, 24'hA5C3F0, 24, -1, 4'hF, -1);
        sendFrame(4'b1101, 24'h123456, 24, -1, 4'hF, -1);
        sendFrame(4'b1011, 24'h654321, 24, -1, 4'hF, -1);
        sendFrame(4'b1110, 24'hFFFFFF, 23, -1, 4'hF, -1);
        sendFrame(4'b1110, 24'hFFFFFF, 25, -1, 4'hF, -1);
        sendFrame(4'b1110, 24'h0F0F0F, 24, -1, 4'hF, -1);
        sendFrame(4'b1100, 24'h777777, 24, -1, 4'hF, -1);
        sendFrame(4'b1110, 24'h3C3C3C, 24, 10, 4'b0110, -1);
        sendFrame(4'b0111, 24'h000000, 0, -1, 4'hF, -1);
        sendFrame(4'b1110, 24'hBEEF01, 24, -1, 4'hF, 12);
        sendFrame(4'b1110, 24'hC0FFEE, 24, -1, 4'hF, -1);
        chk("post_reset_count", 32'(bus.FrameCount), 32'h1);

        for (int k = 0; k < 30; k++) begin
            ch = $urandom_range(0, 3);
            cs = ~(4'b0001 << ch);
            r  = $urandom_range(0, 9);
            nb = (r == 0) ? 23 : (r == 1) ? 25 : (r == 2) ? 0 : 24;
            if (r == 3) cs = cs & ~(4'b0001 << ((ch + 1) % 4));
            sendFrame(cs, 24'($urandom), nb, -1, 4'hF, -1);
        end

        chk("final_count", 32'(bus.FrameCount), 32'(mdlCount));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
